// File: rtl/mux_sel_pipe.sv
// Registered N:1 channel selector with a loadable/auto-scanning select register.
// Latency: 1 cycle in_data->out_data (2 with MUX_SEL_PIPE_OUT_EN); sel_load->cur_sel 1 cycle.
// Backpressure: none except hold, which freezes every register; consumer takes out_data whenever out_valid=1 and hold=0.
module mux_sel_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 128,
    parameter int SEL_W = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_load,
    input  logic                    scan_en,
    input  logic                    hold,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    scan_wrap
);

    // Any select at or beyond the last channel wraps on the next scan step,
    // so an out-of-range loaded value also returns to 0 and flags a wrap.
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0] sel_q;
    logic             wrap_q;
    logic [WIDTH-1:0] mux_dat;
    logic [WIDTH-1:0] dat_q;
    logic             vld_q;

    // Channel selector: out-of-range select values fall through to channel 0.
    always_comb begin
        mux_dat = in_data[WIDTH-1:0];
        for (int k = 1; k < N_IN; k++) begin
            if (sel_q == SEL_W'(k)) begin
                mux_dat = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Select register: load beats scan; the wrap flag pulses with the step into 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            wrap_q <= 1'b0;
        end else if (!hold) begin
            if (sel_load) begin
                sel_q  <= sel;
                wrap_q <= 1'b0;
            end else if (scan_en) begin
                if (sel_q >= LAST_SEL) begin
                    sel_q  <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    sel_q  <= sel_q + SEL_W'(1);
                    wrap_q <= 1'b0;
                end
            end else begin
                wrap_q <= 1'b0;
            end
        end
    end

    // Data stage: sample the channel picked by the select value of this same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else if (!hold) begin
            dat_q <= mux_dat;
            vld_q <= in_valid;
        end
    end

    assign cur_sel = sel_q;

`ifdef MUX_SEL_PIPE_OUT_EN
    logic             wrap_d1;
    logic [WIDTH-1:0] dat_q2;
    logic             vld_q2;
    logic             wrap_q2;

    // Wrap flag delayed alongside the data stage so it lands with channel 0's sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_d1 <= 1'b0;
        end else if (!hold) begin
            wrap_d1 <= wrap_q;
        end
    end

    // Second output stage: retimes data, valid and wrap together off the selector path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q2  <= '0;
            vld_q2  <= 1'b0;
            wrap_q2 <= 1'b0;
        end else if (!hold) begin
            dat_q2  <= dat_q;
            vld_q2  <= vld_q;
            wrap_q2 <= wrap_d1;
        end
    end

    assign out_data  = dat_q2;
    assign out_valid = vld_q2;
    assign scan_wrap = wrap_q2;
`else
    assign out_data  = dat_q;
    assign out_valid = vld_q;
    assign scan_wrap = wrap_q;
`endif

endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised, registered N:1 data selector with a loadable select register, an auto-scan mode and a valid-qualified output pipeline. It generalises the fixed 128-input, 1-bit combinational selector in this family to a configurable data width, input count and select width. It sits between parallel data sources and a single consumer, for example a status/probe readout or a time-multiplexed bus.

## Interface
- `WIDTH`, default 8: data bits per input channel.
- `N_IN`, default 128: number of input channels. Any value from 2 to 2**SEL_W is legal.
- `SEL_W`, default 7: select width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  N_IN*WIDTH: packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  1: the sample on `in_data` is valid this cycle.
- `sel`  in  SEL_W: channel index to load.
- `sel_load`  in  1: load `sel` into the select register.
- `scan_en`  in  1: 1 selects auto-scan mode; 0 selects held-select mode.
- `hold`  in  1: freezes every register in the block (stall).
- `out_data`  out  WIDTH: selected channel data, registered.
- `out_valid`  out  1: `out_data` is valid.
- `cur_sel`  out  SEL_W: current value of the select register.
- `scan_wrap`  out  1: one-cycle pulse when scan wraps from N_IN-1 to 0.

## Operation
- Select register `sel_q`:
  - When `sel_load`=1, it loads `sel`.
  - Otherwise, when `scan_en`=1, it increments by 1, wrapping from N_IN-1 to 0.
  - Otherwise it holds.
- `sel_load` has priority over a scan increment in the same cycle. The scan resumes from the loaded value on the next cycle.
- `scan_wrap` is registered. It is 1 in the cycle after an increment that moved `sel_q` from N_IN-1 to 0. A load to 0 never raises it.
- Out-of-range select: if `sel_q` ≥ N_IN (possible only when N_IN < 2**SEL_W), the selected data is channel 0, as in the combinational selector.
- If `sel_load` carries an out-of-range value while `scan_en`=1, the next increment wraps to 0 and raises `scan_wrap`.
- Data stage: `out_data` registers `in_data[sel_q]`, and `out_valid` registers `in_valid`. Both use the select value present in the same cycle as the sampled data.
- `cur_sel` is a direct output of `sel_q`.
- `hold`=1 freezes all registers, including `sel_q`, the scan counter, the output stage and `scan_wrap`. It overrides `sel_load` and `scan_en`.
- `hold` while `scan_wrap`=1 keeps the pulse asserted for the duration of the hold.

## Timing
- Reset (asynchronous assert, synchronous release on the first `clk` edge after `rst_n` rises) sets:
  - `sel_q`=0
  - `out_data`=0
  - `out_valid`=0
  - `scan_wrap`=0
  - pipeline stage registers=0
- Reset mid-scan discards the scan position; the scan restarts at channel 0.
- Latency from `in_data`/`in_valid` at edge t to `out_data`/`out_valid`: 1 cycle (2 with `MUX_SEL_PIPE_OUT_EN`).
- Latency from `sel_load` at edge t to `cur_sel` update: 1 cycle. Data from the new channel first appears on `out_data` 2 cycles after the load edge (3 with the macro).
- In scan mode with `in_valid` held at 1, `out_data` walks channels 0,1,…,N_IN-1,0… one channel per cycle.
- There is no backpressure other than `hold`. The consumer must accept `out_data` whenever `out_valid`=1 and `hold`=0.

## Configuration
- `MUX_SEL_PIPE_OUT_EN` defined:
  - Adds a second output register stage after the data stage, carrying `out_data`, `out_valid` and `scan_wrap` together.
  - Data latency is 2 cycles, and `scan_wrap` stays aligned with the output sample of channel 0.
  - `hold` freezes both stages.
  - Intended for wide N_IN*WIDTH where the selector limits timing.
- Not defined:
  - Single output stage; latency as given above.
  - `scan_wrap` is aligned with the cycle in which `cur_sel` becomes 0.

## Test plan
- Reset: assert `rst_n`=0 mid-scan at `sel_q`=37 -> all outputs 0 immediately. After release with `scan_en`=1, `cur_sel` sequence is 0,1,2.
- Load: N_IN=128, WIDTH=8, channel k = k+0x10, `sel`=5, `sel_load` pulse, `in_valid`=1 -> `cur_sel`=5 after 1 cycle; `out_data`=0x15, `out_valid`=1 after 2 cycles (3 with macro).
- Scan wrap: load 126, `scan_en`=1 -> `cur_sel` sequence 126,127,0,1. `scan_wrap`=1 only in the cycle `cur_sel`=0 (no macro).
- Load beats scan: `scan_en`=1 and `sel_load`=1 with `sel`=64 in the same cycle as `sel_q`=10 -> `cur_sel`=64, then 65.
- Out of range: N_IN=100, SEL_W=7, load `sel`=110 with `scan_en`=0 -> `out_data` equals channel 0. Repeat with `scan_en`=1 -> next `cur_sel`=0 and `scan_wrap`=1.
- Hold: `hold`=1 for 3 cycles during a scan at `sel_q`=20 -> `cur_sel`, `out_data` and `out_valid` stay constant for those cycles. The scan resumes at 21, and no sample is lost or duplicated beyond the hold.
